pipeline_stall_controller: RTL and testbench

Acts on the pipeline hazard outputs. It enacts load-use stalls and branch flushes, and runs the multi-cycle multiply/divide handshake.
- Drives latch write enables for PC/FD/DX/XM/WB and NOP-injection selects.
- Issues one-cycle ctrl_MULT/ctrl_DIV start pulses and freezes the front of the pipe until the multdiv result is ready.
- Sits between the hazard detection logic, the execute stage and the multdiv unit.

---
 rtl/pipe_ctrl_pkg.sv | 39 +++
 rtl/pipeline_stall_controller_sat_counter.sv | 25 ++
 rtl/pipeline_stall_controller.sv | 177 +++++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, state encoding and instruction decode helpers for the pipeline stall controller.
// Used by both default and STALL_PERF_COUNTERS_EN builds.
package pipe_ctrl_pkg;

    localparam logic [4:0] OP_ALU  = 5'd0;
    localparam logic [4:0] OP_J    = 5'd1;
    localparam logic [4:0] OP_BNE  = 5'd2;
    localparam logic [4:0] OP_JAL  = 5'd3;
    localparam logic [4:0] OP_JR   = 5'd4;
    localparam logic [4:0] OP_ADDI = 5'd5;
    localparam logic [4:0] OP_BLT  = 5'd6;
    localparam logic [4:0] OP_SW   = 5'd7;
    localparam logic [4:0] OP_LW   = 5'd8;
    localparam logic [4:0] OP_SETX = 5'd21;
    localparam logic [4:0] OP_BEX  = 5'd22;

    localparam logic [4:0] ALUOP_MUL = 5'd6;
    localparam logic [4:0] ALUOP_DIV = 5'd7;

    localparam logic [31:0] NOP_WORD = 32'd0;

    // Wide enough for the largest allowed multdiv timeout (255).
    localparam int WAIT_CNT_W = 8;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MD_WAIT = 2'b01
    } md_state_e;

    function automatic logic isMdOp(input logic [31:0] instr);
        return (instr[31:27] == OP_ALU) &&
               ((instr[6:2] == ALUOP_MUL) || (instr[6:2] == ALUOP_DIV));
    endfunction

    function automatic logic isMul(input logic [31:0] instr);
        return instr[6:2] == ALUOP_MUL;
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock) begin
        if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Enacts load-use stalls, branch flushes and the multdiv issue/wait handshake.
// Define STALL_PERF_COUNTERS_EN to add saturating stall/flush performance counters.
module pipeline_stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              DX_stalling_mux_select,
    input  logic [31:0]       DX_Latch_Instr,
    input  logic              branch_taken,
    input  logic              md_result_rdy,
    input  logic              md_exception,
    output logic              PC_we,
    output logic              FD_we,
    output logic              DX_we,
    output logic              XM_we,
    output logic              WB_we,
    output logic              FD_flush,
    output logic              DX_nop_select,
    output logic              XM_nop_select,
    output logic              ctrl_MULT,
    output logic              ctrl_DIV,
    output logic              md_result_we,
    output logic              md_error,
`ifdef STALL_PERF_COUNTERS_EN
    output logic [CNT_W-1:0]  lu_stall_cnt,
    output logic [CNT_W-1:0]  md_stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
`endif
    output logic              md_busy
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LAST = WAIT_CNT_W'(MD_TIMEOUT - 1);

    md_state_e               r_state;
    md_state_e               w_nextState;
    logic [WAIT_CNT_W-1:0]   w_waitCnt;
    logic                    w_mdOp;
    logic                    w_isMul;
    logic                    w_timeout;
    logic                    w_issue;
    logic                    w_waitInc;
    logic                    w_luStall;
    logic                    w_flush;

    assign w_mdOp    = isMdOp(DX_Latch_Instr);
    assign w_isMul   = isMul(DX_Latch_Instr);
    assign w_timeout = (w_waitCnt == TIMEOUT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState   = RUN;
        PC_we         = 1'b1;
        FD_we         = 1'b1;
        DX_we         = 1'b1;
        XM_we         = 1'b1;
        WB_we         = 1'b1;
        FD_flush      = 1'b0;
        DX_nop_select = 1'b0;
        XM_nop_select = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        md_result_we  = 1'b0;
        md_error      = 1'b0;
        md_busy       = 1'b0;
        w_issue       = 1'b0;
        w_waitInc     = 1'b0;
        w_luStall     = 1'b0;
        w_flush       = 1'b0;

        case (r_state)
            RUN: begin
                if (branch_taken) begin
                    FD_flush      = 1'b1;
                    DX_nop_select = 1'b1;
                    w_flush       = 1'b1;
                end else if (DX_stalling_mux_select) begin
                    PC_we         = 1'b0;
                    FD_we         = 1'b0;
                    DX_nop_select = 1'b1;
                    w_luStall     = 1'b1;
                end else if (w_mdOp) begin
                    ctrl_MULT     = w_isMul;
                    ctrl_DIV      = ~w_isMul;
                    PC_we         = 1'b0;
                    FD_we         = 1'b0;
                    DX_we         = 1'b0;
                    XM_nop_select = 1'b1;
                    w_issue       = 1'b1;
                    w_nextState   = MD_WAIT;
                end
            end
            // The mul/div stays frozen in DX, so stall and branch requests cannot be genuine here.
            MD_WAIT: begin
                md_busy = 1'b1;
                if (md_result_rdy) begin
                    md_result_we = 1'b1;
                    md_error     = md_exception;
                end else if (w_timeout) begin
                    md_result_we = 1'b1;
                    md_error     = 1'b1;
                end else begin
                    PC_we         = 1'b0;
                    FD_we         = 1'b0;
                    DX_we         = 1'b0;
                    XM_nop_select = 1'b1;
                    w_waitInc     = 1'b1;
                    w_nextState   = MD_WAIT;
                end
            end
            default: w_nextState = RUN;
        endcase

        if (reset) begin
            w_nextState   = RUN;
            PC_we         = 1'b1;
            FD_we         = 1'b1;
            DX_we         = 1'b1;
            XM_we         = 1'b1;
            WB_we         = 1'b1;
            FD_flush      = 1'b0;
            DX_nop_select = 1'b0;
            XM_nop_select = 1'b0;
            ctrl_MULT     = 1'b0;
            ctrl_DIV      = 1'b0;
            md_result_we  = 1'b0;
            md_error      = 1'b0;
            md_busy       = 1'b0;
            w_issue       = 1'b0;
            w_waitInc     = 1'b0;
            w_luStall     = 1'b0;
            w_flush       = 1'b0;
        end
    end

    sat_counter #(.WIDTH(WAIT_CNT_W)) u_waitCnt (
        .clock (clock),
        .clr   (reset | w_issue),
        .inc   (w_waitInc),
        .count (w_waitCnt)
    );

`ifdef STALL_PERF_COUNTERS_EN
    // MD stall cycles include the issue cycle as well as every MD_WAIT cycle.
    sat_counter #(.WIDTH(CNT_W)) u_luStallCnt (
        .clock (clock),
        .clr   (reset),
        .inc   (w_luStall),
        .count (lu_stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_mdStallCnt (
        .clock (clock),
        .clr   (reset),
        .inc   (w_issue | (r_state == MD_WAIT)),
        .count (md_stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flushCnt (
        .clock (clock),
        .clr   (reset),
        .inc   (w_flush),
        .count (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed self-checking bench for pipeline_stall_controller (MD_TIMEOUT=8).
// Also checks the counters when STALL_PERF_COUNTERS_EN is defined.
module tb_pipeline_stall_controller;

    localparam int CNT_W = 32;

    // Output vector order: PC FD DX XM WB | FDflush DXnop XMnop | MULT DIV | resWe err | busy
    localparam logic [12:0] V_IDLE    = 13'b11111_000_00_00_0;
    localparam logic [12:0] V_LUSTALL = 13'b00111_010_00_00_0;
    localparam logic [12:0] V_BRANCH  = 13'b11111_110_00_00_0;
    localparam logic [12:0] V_MULISS  = 13'b00011_001_10_00_0;
    localparam logic [12:0] V_DIVISS  = 13'b00011_001_01_00_0;
    localparam logic [12:0] V_WAIT    = 13'b00011_001_00_00_1;
    localparam logic [12:0] V_RDYOK   = 13'b11111_000_00_10_1;
    localparam logic [12:0] V_RDYERR  = 13'b11111_000_00_11_1;
    localparam logic [12:0] V_RESET   = 13'b11111_000_00_00_0;

    logic        clock;
    logic        reset;
    logic        DX_stalling_mux_select;
    logic [31:0] DX_Latch_Instr;
    logic        branch_taken;
    logic        md_result_rdy;
    logic        md_exception;
    logic        PC_we, FD_we, DX_we, XM_we, WB_we;
    logic        FD_flush, DX_nop_select, XM_nop_select;
    logic        ctrl_MULT, ctrl_DIV, md_result_we, md_error, md_busy;
`ifdef STALL_PERF_COUNTERS_EN
    logic [CNT_W-1:0] lu_stall_cnt, md_stall_cnt, flush_cnt;
`endif

    int assertCount = 0;
    int failCount   = 0;

    logic [31:0] iMul, iDiv, iAdd, iLw;

    pipeline_stall_controller #(.MD_TIMEOUT(8), .CNT_W(CNT_W)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .DX_stalling_mux_select (DX_stalling_mux_select),
        .DX_Latch_Instr         (DX_Latch_Instr),
        .branch_taken           (branch_taken),
        .md_result_rdy          (md_result_rdy),
        .md_exception           (md_exception),
        .PC_we                  (PC_we),
        .FD_we                  (FD_we),
        .DX_we                  (DX_we),
        .XM_we                  (XM_we),
        .WB_we                  (WB_we),
        .FD_flush               (FD_flush),
        .DX_nop_select          (DX_nop_select),
        .XM_nop_select          (XM_nop_select),
        .ctrl_MULT              (ctrl_MULT),
        .ctrl_DIV               (ctrl_DIV),
        .md_result_we           (md_result_we),
        .md_error               (md_error),
`ifdef STALL_PERF_COUNTERS_EN
        .lu_stall_cnt           (lu_stall_cnt),
        .md_stall_cnt           (md_stall_cnt),
        .flush_cnt              (flush_cnt),
`endif
        .md_busy                (md_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] rType(input logic [4:0] aluOp);
        return {5'd0, 5'd4, 5'd3, 5'd1, 5'd0, aluOp, 2'b00};
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1ns later, well before the next rising edge.
    task automatic applyStimulus(input logic rst, input logic stall, input logic [31:0] instr,
                                 input logic br, input logic rdy, input logic exc);
        @(negedge clock);
        reset                  = rst;
        DX_stalling_mux_select = stall;
        DX_Latch_Instr         = instr;
        branch_taken           = br;
        md_result_rdy          = rdy;
        md_exception           = exc;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [12:0] expected);
        logic [12:0] observed;
        observed = {PC_we, FD_we, DX_we, XM_we, WB_we, FD_flush, DX_nop_select, XM_nop_select,
                    ctrl_MULT, ctrl_DIV, md_result_we, md_error, md_busy};
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic checkCount(input string tag, input logic [CNT_W-1:0] observed,
                              input logic [CNT_W-1:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        iMul = rType(5'd6);
        iDiv = rType(5'd7);
        iAdd = rType(5'd0);
        iLw  = {5'd8, 5'd3, 5'd2, 17'd0};

        reset = 1'b1;
        DX_stalling_mux_select = 1'b0;
        DX_Latch_Instr = 32'd0;
        branch_taken = 1'b0;
        md_result_rdy = 1'b0;
        md_exception = 1'b0;

        $display("[TB] reset");
        applyStimulus(1, 0, 32'd0, 0, 0, 0);
        checkOutput("reset_hold", V_RESET);
        applyStimulus(1, 1, iMul, 1, 1, 1);
        checkOutput("reset_forces_outputs", V_RESET);
        applyStimulus(0, 0, 32'd0, 0, 0, 0);
        checkOutput("idle_after_reset", V_IDLE);

        $display("[TB] load-use stall");
        applyStimulus(0, 1, iLw, 0, 0, 0);
        checkOutput("lu_stall", V_LUSTALL);
        applyStimulus(0, 0, 32'd0, 0, 0, 0);
        checkOutput("lu_release", V_IDLE);

        $display("[TB] mul, rdy at +5");
        applyStimulus(0, 0, iMul, 0, 0, 0);
        checkOutput("mul_issue", V_MULISS);
        applyStimulus(0, 0, iMul, 0, 0, 0);
        checkOutput("mul_wait1", V_WAIT);
        applyStimulus(0, 1, iMul, 1, 0, 0);
        checkOutput("mul_wait2_ignore_br_stall", V_WAIT);
        applyStimulus(0, 0, iMul, 0, 0, 0);
        checkOutput("mul_wait3", V_WAIT);
        applyStimulus(0, 0, iMul, 0, 0, 0);
        checkOutput("mul_wait4", V_WAIT);
        applyStimulus(0, 0, iMul, 0, 1, 0);
        checkOutput("mul_rdy", V_RDYOK);
        applyStimulus(0, 0, iAdd, 0, 0, 0);
        checkOutput("mul_back_run_no_repulse", V_IDLE);

        $display("[TB] div, rdy at +3 with exception");
        applyStimulus(0, 0, iDiv, 0, 0, 0);
        checkOutput("div_issue", V_DIVISS);
        for (int c = 1; c <= 2; c++) begin
            applyStimulus(0, 0, iDiv, 0, 0, 0);
            checkOutput("div_wait", V_WAIT);
        end
        applyStimulus(0, 0, iDiv, 0, 1, 1);
        checkOutput("div_rdy_exc", V_RDYERR);
        applyStimulus(0, 0, 32'd0, 0, 0, 0);
        checkOutput("div_back_run", V_IDLE);

        $display("[TB] div timeout");
        applyStimulus(0, 0, iDiv, 0, 0, 0);
        checkOutput("to_issue", V_DIVISS);
        for (int c = 1; c <= 7; c++) begin
            applyStimulus(0, 0, iDiv, 0, 0, 0);
            checkOutput("to_wait", V_WAIT);
        end
        applyStimulus(0, 0, iDiv, 0, 0, 0);
        checkOutput("to_forced_abort", V_RDYERR);
        applyStimulus(0, 0, 32'd0, 0, 0, 0);
        checkOutput("to_back_run", V_IDLE);

        $display("[TB] branch priority and stray rdy");
        applyStimulus(0, 1, iLw, 1, 0, 0);
        checkOutput("branch_over_stall", V_BRANCH);
        applyStimulus(0, 0, 32'd0, 0, 1, 1);
        checkOutput("rdy_in_run_ignored", V_IDLE);

`ifdef STALL_PERF_COUNTERS_EN
        checkCount("lu_stall_cnt", lu_stall_cnt, 32'd1);
        checkCount("md_stall_cnt", md_stall_cnt, 32'd19);
        checkCount("flush_cnt", flush_cnt, 32'd1);
`endif

        $display("[TB] reset during MD_WAIT");
        applyStimulus(0, 0, iDiv, 0, 0, 0);
        checkOutput("rst_div_issue", V_DIVISS);
        applyStimulus(0, 0, iDiv, 0, 0, 0);
        checkOutput("rst_wait1", V_WAIT);
        applyStimulus(0, 0, iDiv, 0, 0, 0);
        checkOutput("rst_wait2", V_WAIT);
        applyStimulus(1, 0, iDiv, 0, 0, 0);
        checkOutput("rst_in_wait_forced", V_RESET);
        applyStimulus(0, 0, 32'd0, 0, 0, 0);
        checkOutput("rst_back_run", V_IDLE);
`ifdef STALL_PERF_COUNTERS_EN
        checkCount("lu_stall_cnt_rst", lu_stall_cnt, 32'd0);
        checkCount("md_stall_cnt_rst", md_stall_cnt, 32'd0);
        checkCount("flush_cnt_rst", flush_cnt, 32'd0);
`endif

        $display("[TB] full timeout after reset");
        applyStimulus(0, 0, iMul, 0, 0, 0);
        checkOutput("post_rst_mul_issue", V_MULISS);
        for (int c = 1; c <= 7; c++) begin
            applyStimulus(0, 0, iMul, 0, 0, 0);
            checkOutput("post_rst_wait", V_WAIT);
        end
        applyStimulus(0, 0, iMul, 0, 0, 0);
        checkOutput("post_rst_forced_abort", V_RDYERR);
        applyStimulus(0, 0, 32'd0, 0, 0, 0);
        checkOutput("post_rst_back_run", V_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
